// File: rtl/encode_64b_67b_pkg.sv
// encode_64b_67b_pkg: shared 64B/67B framing constants and types for the TX encoder and RX decoder.
package encode_64b_67b_pkg;
   localparam int PAYLOAD_W = 64;
   localparam int BLOCK_W   = 67;
   localparam int RD_BOUND  = 69;

   typedef enum logic [1:0] {
      HDR_BAD0 = 2'b00,
      HDR_DATA = 2'b01,
      HDR_CTRL = 2'b10,
      HDR_BAD3 = 2'b11
   } hdr_e;

   typedef struct packed {
      logic                 valid;
      logic                 pt;
      logic [1:0]           hdr;
      logic [PAYLOAD_W-1:0] data;
      logic [6:0]           ones;
   } s1_t;

   function automatic logic hdr_ok(input logic [1:0] h);
      return h == HDR_DATA || h == HDR_CTRL;
   endfunction
endpackage

// File: rtl/encode_64b_67b_if.sv
// encode_64b_67b_if: payload-in / block-out bus of the 64B/67B encoder.
interface encode_64b_67b_if #(parameter int DISP_WIDTH = 8);
   import encode_64b_67b_pkg::*;
   logic [PAYLOAD_W-1:0]         i_data_in;
   logic [1:0]                   i_header_in;
   logic                         i_data_valid;
   logic                         i_passthrough;
   logic [BLOCK_W-1:0]           o_data_out;
   logic                         o_valid_out;
   logic                         o_header_err;
   logic signed [DISP_WIDTH-1:0] o_disparity;
   modport slave (
      input  i_data_in, i_header_in, i_data_valid, i_passthrough,
      output o_data_out, o_valid_out, o_header_err, o_disparity
   );
   modport master (
      output i_data_in, i_header_in, i_data_valid, i_passthrough,
      input  o_data_out, o_valid_out, o_header_err, o_disparity
   );
endinterface

// File: rtl/encode_64b_67b_popcount.sv
// popcount_64: combinational ones count of a 64-bit word.
module popcount_64 (
   input  logic [63:0] i_data,
   output logic [6:0]  o_ones
);
   always_comb begin
      o_ones = '0;
      for (int k = 0; k < 64; k++) o_ones = o_ones + {6'd0, i_data[k]};
   end
endmodule

// File: rtl/encode_64b_67b.sv
// encode_64b_67b: Interlaken TX 64B/67B encoder, 2-stage pipe with running-disparity inversion.
module encode_64b_67b
   import encode_64b_67b_pkg::*;
#(
   parameter int DISP_WIDTH = 8,
   parameter bit HDR_CHECK  = 1'b1
) (
   input logic              i_clk,
   input logic              i_rst,
   encode_64b_67b_if.slave  bus
);
   logic [6:0]                   w_ones;
   logic [1:0]                   w_hp;
   logic signed [DISP_WIDTH-1:0] w_d, w_d_inv, w_rd_next;
   logic                         w_inv;
   s1_t                          r_s1;
   logic [BLOCK_W-1:0]           r_out;
   logic                         r_valid, r_err;
   logic signed [DISP_WIDTH-1:0] r_rd;

   popcount_64 u_pop (.i_data(bus.i_data_in), .o_ones(w_ones));

   // The INV bit counts as a zero in D and as a one in D'; the header is never inverted.
   always_comb begin
      w_hp      = {1'b0, r_s1.hdr[0]} + {1'b0, r_s1.hdr[1]};
      w_d       = DISP_WIDTH'(2 * (int'(r_s1.ones) + int'(w_hp)) - 67);
      w_d_inv   = DISP_WIDTH'(2 * (65 - int'(r_s1.ones) + int'(w_hp)) - 67);
      w_inv     = !r_s1.pt && r_rd != '0 && w_d[DISP_WIDTH-1] == r_rd[DISP_WIDTH-1];
      w_rd_next = r_s1.pt ? '0 : r_rd + (w_inv ? w_d_inv : w_d);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1    <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_rd    <= '0;
      end else begin
         r_s1    <= '{bus.i_data_valid, bus.i_passthrough, bus.i_header_in, bus.i_data_in, w_ones};
         r_valid <= r_s1.valid;
         if (r_s1.valid) begin
            r_out <= {w_inv, r_s1.hdr, w_inv ? ~r_s1.data : r_s1.data};
            r_err <= HDR_CHECK && !hdr_ok(r_s1.hdr);
            r_rd  <= w_rd_next;
         end
      end
   end

   assign bus.o_data_out   = r_out;
   assign bus.o_valid_out  = r_valid;
   assign bus.o_header_err = r_err;
   assign bus.o_disparity  = r_rd;
endmodule
